// File: rtl/retire_rat.sv
// Retirement register alias table.
// Holds the committed arch->phys mapping, updated by in-order commits from the ROB head.
// Each displaced physical register goes into a small FIFO and is handed back to the free
// list over a valid/ready handshake. Commit is back-pressured only while that FIFO is full.
module retire_rat #(
  parameter int NUM_ARCH_REG = 32,
  parameter int PHYS_IDX_W   = 6,
  parameter int FREE_Q_DEPTH = 4,
  localparam int ARCH_IDX_W  = $clog2(NUM_ARCH_REG),
  localparam int CNT_W       = $clog2(FREE_Q_DEPTH) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               commit_valid,
  output logic                               commit_ready,
  input  logic [ARCH_IDX_W-1:0]              commit_rd,
  input  logic [PHYS_IDX_W-1:0]              commit_pd,
  input  logic                               commit_mispredict,
  output logic [NUM_ARCH_REG*PHYS_IDX_W-1:0] rrat_mapping,
  output logic                               update_rat,
  output logic [ARCH_IDX_W-1:0]              rob_rd,
  output logic [PHYS_IDX_W-1:0]              rob_pd,
  output logic                               flush,
  output logic                               free_valid,
  input  logic                               free_ready,
  output logic [PHYS_IDX_W-1:0]              free_pd,
  output logic [CNT_W-1:0]                   free_count
);

  localparam int PTR_W = $clog2(FREE_Q_DEPTH);

  logic [PHYS_IDX_W-1:0] map_q  [NUM_ARCH_REG];
  logic [PHYS_IDX_W-1:0] map_d  [NUM_ARCH_REG];
  logic [PHYS_IDX_W-1:0] fifo_q [FREE_Q_DEPTH];
  logic [PHYS_IDX_W-1:0] fifo_d [FREE_Q_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  commit_fire;
  logic                  push;
  logic                  pop;

  // Handshake and RAT-facing outputs; ready depends only on the registered occupancy,
  // and a commit seen while reset is asserted is dropped.
  always_comb begin
    commit_ready = (count_q != CNT_W'(FREE_Q_DEPTH));
    commit_fire  = commit_valid && commit_ready && !rst;
    update_rat   = commit_fire && (commit_rd != '0);
    flush        = commit_fire && commit_mispredict;
    rob_rd       = commit_rd;
    rob_pd       = commit_pd;
    push         = update_rat;
    free_valid   = (count_q != '0);
    free_pd      = fifo_q[rd_ptr_q];
    free_count   = count_q;
    pop          = free_valid && free_ready;
  end

  // Flatten the registered table so entry i sits at bits [i*PHYS_IDX_W +: PHYS_IDX_W].
  always_comb begin
    rrat_mapping = '0;
    for (int i = 0; i < NUM_ARCH_REG; i++) begin
      rrat_mapping[i*PHYS_IDX_W +: PHYS_IDX_W] = map_q[i];
    end
  end

  // Next state: write the new mapping, queue the displaced preg and advance the FIFO pointers.
  always_comb begin
    map_d    = map_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      map_d[commit_rd]  = commit_pd;
      fifo_d[wr_ptr_q]  = map_q[commit_rd];
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset restores the identity mapping and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH_REG; i++) begin
        map_q[i] <= PHYS_IDX_W'(i);
      end
      for (int j = 0; j < FREE_Q_DEPTH; j++) begin
        fifo_q[j] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      map_q    <= map_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_retire_rat.sv
// Self-checking bench for retire_rat: a queue/array model checked every cycle plus
// hand-computed literal expectations for the directed scenarios.
module tb_retire_rat;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         commit_valid = 1'b0;
  logic         commit_ready;
  logic [4:0]   commit_rd = '0;
  logic [5:0]   commit_pd = '0;
  logic         commit_mispredict = 1'b0;
  logic [191:0] rrat_mapping;
  logic         update_rat;
  logic [4:0]   rob_rd;
  logic [5:0]   rob_pd;
  logic         flush;
  logic         free_valid;
  logic         free_ready = 1'b0;
  logic [5:0]   free_pd;
  logic [2:0]   free_count;

  int errors = 0;
  int checks = 0;

  int model_map [32];
  int free_q [$];
  bit m_fire;

  retire_rat dut (
    .clk               (clk),
    .rst               (rst),
    .commit_valid      (commit_valid),
    .commit_ready      (commit_ready),
    .commit_rd         (commit_rd),
    .commit_pd         (commit_pd),
    .commit_mispredict (commit_mispredict),
    .rrat_mapping      (rrat_mapping),
    .update_rat        (update_rat),
    .rob_rd            (rob_rd),
    .rob_pd            (rob_pd),
    .flush             (flush),
    .free_valid        (free_valid),
    .free_ready        (free_ready),
    .free_pd           (free_pd),
    .free_count        (free_count)
  );

  // Free-running clock, rising edge at 5 + 10k.
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_map[i] = i;
    free_q.delete();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Compare every DUT output against what the model says it must be right now.
  task automatic checkOutput();
    bit ready;
    bit fire;
    logic [191:0] exp_map;
    ready = (free_q.size() < 4);
    fire  = commit_valid && ready && !rst;
    chk("commit_ready", int'(commit_ready), int'(ready));
    chk("update_rat", int'(update_rat), int'(fire && (commit_rd != 0)));
    chk("flush", int'(flush), int'(fire && commit_mispredict));
    chk("free_valid", int'(free_valid), int'(free_q.size() > 0));
    chk("free_count", int'(free_count), free_q.size());
    if (free_q.size() > 0) chk("free_pd", int'(free_pd), free_q[0]);
    if (commit_valid) begin
      chk("rob_rd", int'(rob_rd), int'(commit_rd));
      chk("rob_pd", int'(rob_pd), int'(commit_pd));
    end
    for (int i = 0; i < 32; i++) exp_map[i*6 +: 6] = 6'(model_map[i]);
    checks++;
    if (rrat_mapping !== exp_map) begin
      errors++;
      $display("[TB] FAIL rrat_mapping: actual=%h required=%h", rrat_mapping, exp_map);
    end
  endtask

  // Compare process: outputs are sampled 2 time units after the falling edge.
  always @(negedge clk) begin
    #2;
    checkOutput();
  end

  // Model state advance on each rising edge: pop first, then accepted commit pushes the old mapping.
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      m_fire = commit_valid && (free_q.size() < 4);
      if (free_q.size() > 0 && free_ready) void'(free_q.pop_front());
      if (m_fire && commit_rd != 0) begin
        free_q.push_back(model_map[commit_rd]);
        model_map[commit_rd] = commit_pd;
      end
    end
  end

  task automatic applyStimulus(input bit v, input int rd, input int pd, input bit mis, input bit fr);
    @(negedge clk);
    commit_valid      = v;
    commit_rd         = 5'(rd);
    commit_pd         = 6'(pd);
    commit_mispredict = mis;
    free_ready        = fr;
    #3;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) chk("reset_map", int'(rrat_mapping[i*6 +: 6]), i);
    chk("reset_free_valid", int'(free_valid), 0);
    chk("reset_commit_ready", int'(commit_ready), 1);

    // Single commit rd=5 pd=40
    applyStimulus(1, 5, 40, 0, 1);
    chk("t2_update_rat", int'(update_rat), 1);
    applyStimulus(0, 0, 0, 0, 1);
    chk("t2_map5", int'(rrat_mapping[5*6 +: 6]), 40);
    chk("t2_free_valid", int'(free_valid), 1);
    chk("t2_free_pd", int'(free_pd), 5);
    applyStimulus(0, 0, 0, 0, 1);
    chk("t2_free_count", int'(free_count), 0);

    // Fill the FIFO, stall, then drain in order
    for (int k = 1; k <= 4; k++) applyStimulus(1, k, 32 + k, 0, 0);
    applyStimulus(1, 6, 37, 0, 0);
    chk("t3_ready_full", int'(commit_ready), 0);
    chk("t3_count_full", int'(free_count), 4);
    chk("t3_stall_update", int'(update_rat), 0);
    applyStimulus(1, 6, 37, 0, 1);
    chk("t3_pop1", int'(free_pd), 1);
    chk("t3_still_stalled", int'(commit_ready), 0);
    applyStimulus(1, 6, 37, 0, 1);
    chk("t3_pop2", int'(free_pd), 2);
    chk("t3_fifth_accept", int'(update_rat), 1);
    chk("t3_count3", int'(free_count), 3);
    applyStimulus(0, 0, 0, 0, 1);
    chk("t3_pop3", int'(free_pd), 3);
    applyStimulus(0, 0, 0, 0, 1);
    chk("t3_pop4", int'(free_pd), 4);
    applyStimulus(0, 0, 0, 0, 1);
    chk("t3_pop_old6", int'(free_pd), 6);
    applyStimulus(0, 0, 0, 0, 1);
    chk("t3_drained", int'(free_count), 0);

    // rd=0 commits
    applyStimulus(1, 0, 50, 0, 1);
    chk("t4_rd0_update", int'(update_rat), 0);
    chk("t4_rd0_ready", int'(commit_ready), 1);
    applyStimulus(1, 0, 50, 1, 1);
    chk("t4_rd0_flush", int'(flush), 1);
    chk("t4_rd0_update_mis", int'(update_rat), 0);
    applyStimulus(0, 0, 0, 0, 1);
    chk("t4_no_push", int'(free_valid), 0);
    chk("t4_map0", int'(rrat_mapping[5:0]), 0);

    // Mispredicting commit rd=7 pd=45
    applyStimulus(1, 7, 45, 1, 1);
    chk("t5_flush", int'(flush), 1);
    chk("t5_update", int'(update_rat), 1);
    chk("t5_rob_rd", int'(rob_rd), 7);
    chk("t5_rob_pd", int'(rob_pd), 45);
    chk("t5_map7_before", int'(rrat_mapping[7*6 +: 6]), 7);
    applyStimulus(0, 0, 0, 0, 1);
    chk("t5_map7_after", int'(rrat_mapping[7*6 +: 6]), 45);
    chk("t5_free_pd", int'(free_pd), 7);

    // Three entries queued, then reset mid-commit
    for (int k = 0; k < 3; k++) applyStimulus(1, 10 + k, 1 + k, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    chk("t6_count3", int'(free_count), 3);
    @(negedge clk);
    commit_valid = 1'b1;
    commit_rd    = 5'd9;
    commit_pd    = 6'd20;
    free_ready   = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    #2;
    chk("t6_rst_count", int'(free_count), 0);
    chk("t6_rst_free_valid", int'(free_valid), 0);
    chk("t6_rst_update", int'(update_rat), 0);
    chk("t6_rst_ready", int'(commit_ready), 1);
    chk("t6_rst_map10", int'(rrat_mapping[10*6 +: 6]), 10);
    applyStimulus(1, 9, 20, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    chk("t6_map9_dropped", int'(rrat_mapping[9*6 +: 6]), 9);

    // Simultaneous push and pop with three entries queued
    for (int k = 1; k <= 3; k++) applyStimulus(1, k, 40 + k, 0, 0);
    applyStimulus(1, 4, 44, 0, 1);
    chk("t7_push_pop_pd", int'(free_pd), 1);
    applyStimulus(0, 0, 0, 0, 0);
    chk("t7_count_held", int'(free_count), 3);
    chk("t7_head", int'(free_pd), 2);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 1);
    chk("t7_drained", int'(free_count), 0);
    chk("t7_map4", int'(rrat_mapping[4*6 +: 6]), 44);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
